// File: rtl/alu_pkg.sv
// Shared wide-ALU definitions: byte width, sequencer state encoding and flag bit positions.
package alu_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic {
        ST_FIRST = 1'b0,
        ST_MID   = 1'b1
    } seq_state_t;

    localparam int FLG_CARRY = 0;
    localparam int FLG_OVF   = 1;
    localparam int FLG_ZERO  = 2;
    localparam int FLG_ERR   = 3;
    localparam int FLG_W     = 4;

endpackage

// File: rtl/cla8b.sv
// Combinational byte adder with fully expanded carry lookahead (no ripple chain).
module cla8b
    import alu_pkg::*;
(
    input  logic [BYTE_W-1:0] a,
    input  logic [BYTE_W-1:0] b,
    input  logic              cin,
    output logic [BYTE_W-1:0] sum,
    output logic              cout
);

    logic [BYTE_W-1:0] g, p;
    logic [BYTE_W:0]   c;

    assign g = a & b;
    assign p = a ^ b;

    // Each carry is a flat sum of products over all lower generate/propagate terms.
    always_comb begin
        logic pp;
        c    = '0;
        c[0] = cin;
        for (int i = 0; i < BYTE_W; i++) begin
            c[i+1] = g[i];
            pp     = p[i];
            for (int j = i - 1; j >= 0; j--) begin
                c[i+1] = c[i+1] | (pp & g[j]);
                pp     = pp & p[j];
            end
            c[i+1] = c[i+1] | (pp & cin);
        end
    end

    assign sum  = p ^ c[BYTE_W-1:0];
    assign cout = c[BYTE_W];

endmodule

// File: rtl/multibyte_add_seq.sv
// Byte-serial multi-precision add/subtract: LSB-first beats, carry held between beats,
// one registered result byte per beat with carry/overflow/zero/error flags on the closing beat.
module multibyte_add_seq
    import alu_pkg::*;
#(
    parameter int NBYTES = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              op_sub,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [BYTE_W-1:0] in_a,
    input  logic [BYTE_W-1:0] in_b,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [BYTE_W-1:0] out_sum,
    output logic              out_last,
    output logic              out_carry,
    output logic              out_ovf,
    output logic              out_zero,
    output logic              out_err
);

    localparam int CW = (NBYTES > 1) ? $clog2(NBYTES) : 1;

    seq_state_t        state;
    logic [CW-1:0]     cnt;
    logic              carry_q;
    logic              op_eff_q;
    logic              zero_q;
    logic [FLG_W-1:0]  flags_q;

    logic              accept, first, close, op_eff, cin, cout, zero_run;
    logic [BYTE_W-1:0] b_eff, sum;
    logic [FLG_W-1:0]  flags_d;

    assign in_ready = !out_valid | out_ready;
    assign accept   = in_valid & in_ready;
    assign first    = (state == ST_FIRST);
    assign close    = in_last | (cnt == CW'(NBYTES - 1));
    assign op_eff   = first ? op_sub : op_eff_q;
    assign b_eff    = op_eff ? ~in_b : in_b;
    assign cin      = first ? op_sub : carry_q;
    assign zero_run = (sum == '0) & (first | zero_q);

    cla8b u_cla (
        .a    (in_a),
        .b    (b_eff),
        .cin  (cin),
        .sum  (sum),
        .cout (cout)
    );

    always_comb begin
        flags_d = '0;
        if (close) begin
            flags_d[FLG_CARRY] = cout;
            flags_d[FLG_OVF]   = (in_a[BYTE_W-1] == b_eff[BYTE_W-1]) & (sum[BYTE_W-1] != in_a[BYTE_W-1]);
            flags_d[FLG_ZERO]  = zero_run;
            flags_d[FLG_ERR]   = !in_last;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ST_FIRST;
            cnt       <= '0;
            carry_q   <= 1'b0;
            op_eff_q  <= 1'b0;
            zero_q    <= 1'b0;
            out_valid <= 1'b0;
            out_sum   <= '0;
            out_last  <= 1'b0;
            flags_q   <= '0;
        end else if (accept) begin
            state     <= close ? ST_FIRST : ST_MID;
            cnt       <= close ? '0 : cnt + CW'(1);
            carry_q   <= cout;
            op_eff_q  <= op_eff;
            zero_q    <= zero_run;
            out_valid <= 1'b1;
            out_sum   <= sum;
            out_last  <= close;
            flags_q   <= flags_d;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    assign out_carry = flags_q[FLG_CARRY];
    assign out_ovf   = flags_q[FLG_OVF];
    assign out_zero  = flags_q[FLG_ZERO];
    assign out_err   = flags_q[FLG_ERR];

endmodule

// File: tb/tb_multibyte_add_seq.sv
// Directed bench for multibyte_add_seq: operation table plus backpressure, forced-close and reset sequences.
module tb_multibyte_add_seq;

    logic       clk = 1'b0;
    logic       rst_n, op_sub, in_valid, in_ready, in_last;
    logic [7:0] in_a, in_b, out_sum;
    logic       out_valid, out_ready, out_last, out_carry, out_ovf, out_zero, out_err;

    int total = 0;
    int bad   = 0;

    multibyte_add_seq #(.NBYTES(4)) dut (
        .clk(clk), .rst_n(rst_n), .op_sub(op_sub), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready),
        .out_sum(out_sum), .out_last(out_last), .out_carry(out_carry), .out_ovf(out_ovf),
        .out_zero(out_zero), .out_err(out_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        sub;
        int          nb;
        logic [31:0] res;
        logic [3:0]  flags;   // {carry, ovf, zero, err}
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Present one beat, let it be accepted at the next edge, then check the registered output.
    task automatic beat(input logic [7:0] a, input logic [7:0] b, input logic sub, input logic last,
                        input logic [7:0] es, input logic el, input logic [3:0] ef);
        in_a = a; in_b = b; op_sub = sub; in_last = last; in_valid = 1'b1;
        chk("in_ready_pre", {31'd0, in_ready}, 32'd1);
        @(posedge clk); #1;
        chk("out_valid", {31'd0, out_valid}, 32'd1);
        chk("out_sum", {24'd0, out_sum}, {24'd0, es});
        chk("out_last", {31'd0, out_last}, {31'd0, el});
        chk("flags", {28'd0, out_carry, out_ovf, out_zero, out_err}, {28'd0, ef});
    endtask

    task automatic idle_drain();
        in_valid = 1'b0;
        @(posedge clk); #1;
        chk("drained", {31'd0, out_valid}, 32'd0);
    endtask

    vec_t vecs[8];

    initial begin
        vecs[0] = '{32'h00FF_FFFF, 32'h0000_0001, 1'b0, 4, 32'h0100_0000, 4'b0000};
        vecs[1] = '{32'h0000_0005, 32'h0000_0005, 1'b1, 4, 32'h0000_0000, 4'b1010};
        vecs[2] = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 4, 32'h8000_0000, 4'b0100};
        vecs[3] = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 4, 32'h0000_0000, 4'b1010};
        vecs[4] = '{32'h0000_0003, 32'h0000_0005, 1'b1, 1, 32'h0000_00FE, 4'b0000};
        vecs[5] = '{32'h0000_0080, 32'h0000_0080, 1'b0, 1, 32'h0000_0000, 4'b1110};
        vecs[6] = '{32'h0000_0100, 32'h0000_0001, 1'b1, 2, 32'h0000_00FF, 4'b1000};
        vecs[7] = '{32'h0000_0080, 32'h0000_0001, 1'b1, 1, 32'h0000_007F, 4'b1100};

        rst_n = 1'b0; op_sub = 1'b0; in_valid = 1'b0; in_last = 1'b0;
        in_a = 8'h00; in_b = 8'h00; out_ready = 1'b1;
        @(posedge clk); @(posedge clk); #1;
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_sum", {24'd0, out_sum}, 32'd0);
        chk("rst_flags", {26'd0, out_last, out_carry, out_ovf, out_zero, out_err, in_ready}, 32'd1);
        rst_n = 1'b1;

        for (int v = 0; v < 8; v++) begin
            for (int i = 0; i < vecs[v].nb; i++) begin
                logic l;
                l = (i == vecs[v].nb - 1);
                beat(vecs[v].a[8*i +: 8], vecs[v].b[8*i +: 8], vecs[v].sub, l,
                     vecs[v].res[8*i +: 8], l, l ? vecs[v].flags : 4'b0000);
            end
            idle_drain();
        end

        // Backpressure: 0x04030201 + 0x10101010 = 0x14131211, stall after beat 2.
        beat(8'h01, 8'h10, 1'b0, 1'b0, 8'h11, 1'b0, 4'b0000);
        beat(8'h02, 8'h10, 1'b0, 1'b0, 8'h12, 1'b0, 4'b0000);
        out_ready = 1'b0; in_a = 8'h03; in_b = 8'h10; in_last = 1'b0; in_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
            chk("bp_valid", {31'd0, out_valid}, 32'd1);
            chk("bp_sum_held", {24'd0, out_sum}, 32'h12);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_resume_sum", {24'd0, out_sum}, 32'h13);
        chk("bp_resume_last", {31'd0, out_last}, 32'd0);
        beat(8'h04, 8'h10, 1'b0, 1'b1, 8'h14, 1'b1, 4'b0000);
        idle_drain();

        // Forced close at beat 4 leaves carry_q=1; beat 5 must start fresh with cin=op_sub=0.
        beat(8'h01, 8'h01, 1'b0, 1'b0, 8'h02, 1'b0, 4'b0000);
        beat(8'h01, 8'h01, 1'b0, 1'b0, 8'h02, 1'b0, 4'b0000);
        beat(8'h01, 8'h01, 1'b0, 1'b0, 8'h02, 1'b0, 4'b0000);
        beat(8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 4'b1001);
        beat(8'h01, 8'h01, 1'b0, 1'b1, 8'h02, 1'b1, 4'b0000);
        idle_drain();
        // Same, but beat 5 is a subtract: 0x05 - 0x03 = 0x02, no borrow.
        for (int k = 0; k < 3; k++) beat(8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 4'b0000);
        beat(8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1, 4'b0011);
        beat(8'h05, 8'h03, 1'b1, 1'b1, 8'h02, 1'b1, 4'b1000);
        idle_drain();

        // Reset mid-operation after two beats that leave carry_q=1.
        beat(8'hFF, 8'hFF, 1'b0, 1'b0, 8'hFE, 1'b0, 4'b0000);
        beat(8'hFF, 8'hFF, 1'b0, 1'b0, 8'hFF, 1'b0, 4'b0000);
        in_valid = 1'b0; rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk("mid_rst_valid", {31'd0, out_valid}, 32'd0);
        chk("mid_rst_sum", {24'd0, out_sum}, 32'd0);
        chk("mid_rst_last", {31'd0, out_last}, 32'd0);
        beat(8'h01, 8'h01, 1'b0, 1'b1, 8'h02, 1'b1, 4'b0000);
        idle_drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
